// File: rtl/ieeedrv_trkio_if.sv
// SD image transfer interface for the IEEE drive track sequencer.
// One request/acknowledge channel per subdrive; the sequencer is the master,
// the SD image controller is the slave.
interface ieeedrv_trkio_if #(
  parameter int SUBDRV = 2
);
  logic [SUBDRV-1:0][31:0] sd_lba;
  logic [SUBDRV-1:0][5:0]  sd_blk_cnt;
  logic [SUBDRV-1:0]       sd_rd;
  logic [SUBDRV-1:0]       sd_wr;
  logic [SUBDRV-1:0]       sd_ack;

  modport master (
    output sd_lba,
    output sd_blk_cnt,
    output sd_rd,
    output sd_wr,
    input  sd_ack
  );

  modport slave (
    input  sd_lba,
    input  sd_blk_cnt,
    input  sd_rd,
    input  sd_wr,
    output sd_ack
  );
endinterface

// File: rtl/ieeedrv_trkio.sv
// Track transfer sequencer for the 4040/8250 IEEE drive.
// Maps the selected subdrive's head position to an SD sector range, writes
// back a dirty track buffer, reads the new track and tags what is resident.
module ieeedrv_trkio #(
  parameter int SUBDRV = 2
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   drv_type,
  input  logic [SUBDRV-1:0]      mounted,
  input  logic [SUBDRV-1:0]      loaded,
  input  logic [SUBDRV-1:0]      drv_mtr,
  input  logic                   drv_sel,
  input  logic                   drv_hd,
  input  logic [SUBDRV-1:0][6:0] track,
  input  logic [SUBDRV-1:0]      save_track,
  ieeedrv_trkio_if.master        sd,
  output logic                   drv_act,
  output logic [7:0]             ltrack,
  output logic [SUBDRV-1:0]      busy
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CALC       = 3'd1;
  localparam logic [2:0] S_WRITE_REQ  = 3'd2;
  localparam logic [2:0] S_WRITE_WAIT = 3'd3;
  localparam logic [2:0] S_READ_REQ   = 3'd4;
  localparam logic [2:0] S_READ_WAIT  = 3'd5;

  // First 256-byte sector of a track; side 1 of the 8250 follows all of side 0.
  function automatic logic [31:0] trk_lba(input logic t8250, input logic side,
                                          input logic [6:0] trk);
    logic [31:0] t;
    logic [31:0] base;
    t = {25'd0, trk};
    if (!t8250) begin
      if (t <= 32'd17)      base = 32'd21 * (t - 32'd1);
      else if (t <= 32'd24) base = 32'd357 + 32'd19 * (t - 32'd18);
      else if (t <= 32'd30) base = 32'd490 + 32'd18 * (t - 32'd25);
      else                  base = 32'd598 + 32'd17 * (t - 32'd31);
    end else begin
      if (t <= 32'd39)      base = 32'd29 * (t - 32'd1);
      else if (t <= 32'd53) base = 32'd1131 + 32'd27 * (t - 32'd40);
      else if (t <= 32'd64) base = 32'd1509 + 32'd25 * (t - 32'd54);
      else                  base = 32'd1784 + 32'd23 * (t - 32'd65);
    end
    return base + (side ? 32'd2083 : 32'd0);
  endfunction

  // Sectors on the track minus one (the SD block count encoding).
  function automatic logic [5:0] trk_cnt(input logic t8250, input logic [6:0] trk);
    if (!t8250) begin
      if (trk <= 7'd17)      return 6'd20;
      else if (trk <= 7'd24) return 6'd18;
      else if (trk <= 7'd30) return 6'd17;
      else                   return 6'd16;
    end else begin
      if (trk <= 7'd39)      return 6'd28;
      else if (trk <= 7'd53) return 6'd26;
      else if (trk <= 7'd64) return 6'd24;
      else                   return 6'd22;
    end
  endfunction

  logic [2:0]              state_q, state_d;
  logic                    tag_vld_q, tag_vld_d;
  logic                    tag_sub_q, tag_sub_d;
  logic                    tag_side_q, tag_side_d;
  logic [6:0]              tag_trk_q, tag_trk_d;
  logic                    dirty_q, dirty_d;
  logic                    rd_after_q, rd_after_d;
  logic                    xfer_sub_q, xfer_sub_d;
  logic                    xfer_side_q, xfer_side_d;
  logic [6:0]              xfer_trk_q, xfer_trk_d;
  logic                    xfer_inval_q, xfer_inval_d;
  logic [SUBDRV-1:0]       mnt_pend_q, mnt_pend_d;
  logic [SUBDRV-1:0][31:0] lba_q, lba_d;
  logic [SUBDRV-1:0][5:0]  cnt_q, cnt_d;
  logic [SUBDRV-1:0]       rd_q, rd_d;
  logic [SUBDRV-1:0]       wr_q, wr_d;
  logic [SUBDRV-1:0]       busy_q, busy_d;
  logic [SUBDRV-1:0]       xfer_oh;

  logic                    sel;
  logic                    tgt_side;
  logic [6:0]              tgt_trk;
  logic                    tgt_trk_ok;
  logic                    tgt_req_ok;
  logic                    tag_hit;
  logic [SUBDRV-1:0]       mnt_any;
  logic                    tag_gone;
  logic                    xfer_gone;
  logic                    wr_ok;
  logic                    calc_tag;
  logic [31:0]             calc_lba;
  logic [5:0]              calc_cnt;

  assign sel        = (SUBDRV > 1) ? drv_sel : 1'b0;
  assign tgt_side   = drv_hd & drv_type;
  assign tgt_trk    = track[sel];
  assign tgt_trk_ok = (tgt_trk != 7'd0) && (tgt_trk <= (drv_type ? 7'd77 : 7'd35));
  assign tgt_req_ok = tgt_trk_ok && loaded[sel] && drv_mtr[sel];
  assign tag_hit    = tag_vld_q && (tag_sub_q == sel) && (tag_side_q == tgt_side)
                      && (tag_trk_q == tgt_trk);
  // A mount pulse seen while ce was low still counts at the next enabled cycle.
  assign mnt_any    = mnt_pend_q | mounted;
  assign tag_gone   = tag_vld_q && (!loaded[tag_sub_q] || mnt_any[tag_sub_q]);
  assign xfer_gone  = !loaded[xfer_sub_q] || mnt_any[xfer_sub_q];
  // Write-back only makes sense into the image the buffer came from.
  assign wr_ok      = dirty_q && tag_vld_q && !tag_gone;
  // Writes address the resident track; reads address the new target.
  assign calc_tag   = (state_q == S_IDLE) || wr_ok;
  assign calc_lba   = calc_tag ? trk_lba(drv_type, tag_side_q, tag_trk_q)
                               : trk_lba(drv_type, tgt_side, tgt_trk);
  assign calc_cnt   = calc_tag ? trk_cnt(drv_type, tag_trk_q) : trk_cnt(drv_type, tgt_trk);

  // Next-state logic for the transfer sequencer, resident tag and SD outputs.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d      = state_q;
    tag_vld_d    = tag_vld_q;
    tag_sub_d    = tag_sub_q;
    tag_side_d   = tag_side_q;
    tag_trk_d    = tag_trk_q;
    dirty_d      = dirty_q;
    rd_after_d   = rd_after_q;
    xfer_sub_d   = xfer_sub_q;
    xfer_side_d  = xfer_side_q;
    xfer_trk_d   = xfer_trk_q;
    xfer_inval_d = xfer_inval_q;
    lba_d        = lba_q;
    cnt_d        = cnt_q;
    mnt_pend_d   = ce ? '0 : (mnt_pend_q | mounted);

    if (ce) begin
      // New image or image removed: the buffer no longer belongs to anything.
      if (tag_gone) begin
        tag_vld_d = 1'b0;
        dirty_d   = 1'b0;
      end
      if ((state_q == S_READ_REQ || state_q == S_READ_WAIT) && xfer_gone) begin
        xfer_inval_d = 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (!tag_hit && tgt_req_ok) begin
            state_d    = S_CALC;
            xfer_sub_d = sel;
          end else if (wr_ok) begin
            state_d             = S_WRITE_REQ;
            xfer_sub_d          = tag_sub_q;
            rd_after_d          = 1'b0;
            lba_d[tag_sub_q]    = calc_lba;
            cnt_d[tag_sub_q]    = calc_cnt;
          end else if (!tag_hit && !tgt_trk_ok && tag_vld_q) begin
            tag_vld_d = 1'b0;
          end
        end
        S_CALC: begin
          if (wr_ok) begin
            state_d          = S_WRITE_REQ;
            xfer_sub_d       = tag_sub_q;
            rd_after_d       = 1'b1;
            lba_d[tag_sub_q] = calc_lba;
            cnt_d[tag_sub_q] = calc_cnt;
          end else if (tgt_req_ok && !tag_hit) begin
            state_d      = S_READ_REQ;
            xfer_sub_d   = sel;
            xfer_side_d  = tgt_side;
            xfer_trk_d   = tgt_trk;
            xfer_inval_d = 1'b0;
            lba_d[sel]   = calc_lba;
            cnt_d[sel]   = calc_cnt;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WRITE_REQ: begin
          if (sd.sd_ack[xfer_sub_q]) state_d = S_WRITE_WAIT;
        end
        S_WRITE_WAIT: begin
          if (!sd.sd_ack[xfer_sub_q]) begin
            dirty_d = 1'b0;
            state_d = rd_after_q ? S_CALC : S_IDLE;
          end
        end
        S_READ_REQ: begin
          if (sd.sd_ack[xfer_sub_q]) state_d = S_READ_WAIT;
        end
        S_READ_WAIT: begin
          if (!sd.sd_ack[xfer_sub_q]) begin
            state_d    = S_IDLE;
            dirty_d    = 1'b0;
            tag_vld_d  = !xfer_inval_d;
            tag_sub_d  = xfer_sub_q;
            tag_side_d = xfer_side_q;
            tag_trk_d  = xfer_trk_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // The buffer is only writable while it holds a settled track.
    if (save_track[tag_sub_q] && tag_vld_q && tag_vld_d &&
        (state_q == S_IDLE || state_q == S_WRITE_REQ || state_q == S_WRITE_WAIT)) begin
      dirty_d = 1'b1;
    end

    xfer_oh             = '0;
    xfer_oh[xfer_sub_d] = 1'b1;
    busy_d = (state_d != S_IDLE)      ? xfer_oh : '0;
    rd_d   = (state_d == S_READ_REQ)  ? xfer_oh : '0;
    wr_d   = (state_d == S_WRITE_REQ) ? xfer_oh : '0;
  end

  // Sequencer state, resident tag and registered SD/busy outputs.
  always_ff @(posedge clk_sys) begin
    // NOTE: the per-subdrive lba/count registers drive outputs, so they are reset too.
    if (reset) begin
      state_q      <= S_IDLE;
      tag_vld_q    <= 1'b0;
      tag_sub_q    <= 1'b0;
      tag_side_q   <= 1'b0;
      tag_trk_q    <= 7'd0;
      dirty_q      <= 1'b0;
      rd_after_q   <= 1'b0;
      xfer_sub_q   <= 1'b0;
      xfer_side_q  <= 1'b0;
      xfer_trk_q   <= 7'd0;
      xfer_inval_q <= 1'b0;
      mnt_pend_q   <= '0;
      lba_q        <= '0;
      cnt_q        <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      busy_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      tag_vld_q    <= tag_vld_d;
      tag_sub_q    <= tag_sub_d;
      tag_side_q   <= tag_side_d;
      tag_trk_q    <= tag_trk_d;
      dirty_q      <= dirty_d;
      rd_after_q   <= rd_after_d;
      xfer_sub_q   <= xfer_sub_d;
      xfer_side_q  <= xfer_side_d;
      xfer_trk_q   <= xfer_trk_d;
      xfer_inval_q <= xfer_inval_d;
      mnt_pend_q   <= mnt_pend_d;
      lba_q        <= lba_d;
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      busy_q       <= busy_d;
    end
  end

  assign sd.sd_lba     = lba_q;
  assign sd.sd_blk_cnt = cnt_q;
  assign sd.sd_rd      = rd_q;
  assign sd.sd_wr      = wr_q;
  assign busy          = busy_q;
  assign drv_act       = tag_sub_q;
  assign ltrack        = !tag_vld_q ? 8'd0
                       : tag_side_q ? ({1'b0, tag_trk_q} + 8'd77)
                       : {1'b0, tag_trk_q};

endmodule

// File: tb/tb_ieeedrv_trkio.sv
// Directed bench for the IEEE drive track transfer sequencer.
// The bench plays the SD controller, acknowledging each request by hand.
module tb_ieeedrv_trkio;

  logic             clk_sys = 1'b0;
  logic             reset;
  logic             ce;
  logic             drv_type;
  logic [1:0]       mounted;
  logic [1:0]       loaded;
  logic [1:0]       drv_mtr;
  logic             drv_sel;
  logic             drv_hd;
  logic [1:0][6:0]  track;
  logic [1:0]       save_track;
  logic             drv_act;
  logic [7:0]       ltrack;
  logic [1:0]       busy;

  int n_cmp = 0;
  int n_bad = 0;

  ieeedrv_trkio_if #(.SUBDRV(2)) sd ();

  ieeedrv_trkio #(.SUBDRV(2)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce         (ce),
    .drv_type   (drv_type),
    .mounted    (mounted),
    .loaded     (loaded),
    .drv_mtr    (drv_mtr),
    .drv_sel    (drv_sel),
    .drv_hd     (drv_hd),
    .track      (track),
    .save_track (save_track),
    .sd         (sd),
    .drv_act    (drv_act),
    .ltrack     (ltrack),
    .busy       (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Wait (bounded) for any read or write request and capture its fields.
  task automatic wait_req(input int budget, output bit ok, output bit is_wr,
                          output int sub, output logic [31:0] lba, output logic [5:0] cnt);
    ok = 1'b0; is_wr = 1'b0; sub = 0; lba = '0; cnt = '0;
    for (int i = 0; i < budget; i++) begin
      if (sd.sd_rd != 2'b00 || sd.sd_wr != 2'b00) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      is_wr = (sd.sd_wr != 2'b00);
      sub   = (sd.sd_rd[1] || sd.sd_wr[1]) ? 1 : 0;
      lba   = sd.sd_lba[sub];
      cnt   = sd.sd_blk_cnt[sub];
    end
  endtask

  // Acknowledge pulse of two cycles; returns one cycle after ack falls.
  task automatic do_ack(input int sub);
    sd.sd_ack[sub] = 1'b1;
    tick();
    tick();
    sd.sd_ack[sub] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; drv_type = 1'b0; mounted = '0; loaded = '0;
    drv_mtr = '0; drv_sel = 1'b0; drv_hd = 1'b0; track = '0; save_track = '0;
    sd.sd_ack = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (busy !== 2'b00) begin n_bad++; $display("FAIL reset_busy: got %b want 00", busy); end
    n_cmp++; if (sd.sd_rd !== 2'b00 || sd.sd_wr !== 2'b00) begin n_bad++; $display("FAIL reset_req: rd %b wr %b want 00", sd.sd_rd, sd.sd_wr); end
    n_cmp++; if (ltrack !== 8'd0) begin n_bad++; $display("FAIL reset_ltrack: got %0d want 0", ltrack); end
    n_cmp++; if (drv_act !== 1'b0) begin n_bad++; $display("FAIL reset_drv_act: got %b want 0", drv_act); end
    n_cmp++; if (sd.sd_lba !== 64'd0 || sd.sd_blk_cnt !== 12'd0) begin n_bad++; $display("FAIL reset_lba: lba %h cnt %h want 0", sd.sd_lba, sd.sd_blk_cnt); end
  endtask

  task automatic test_read_4040();
    bit ok, is_wr; int sub; logic [31:0] lba; logic [5:0] cnt;
    drv_type = 1'b0; drv_sel = 1'b0; track[0] = 7'd18; loaded = 2'b01; drv_mtr = 2'b01;
    wait_req(20, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (!ok || is_wr || sub != 0) begin n_bad++; $display("FAIL rd18_req: ok %0d wr %0d sub %0d want read sub0", ok, is_wr, sub); end
    n_cmp++; if (lba !== 32'd357 || cnt !== 6'd18) begin n_bad++; $display("FAIL rd18_lba: lba %0d cnt %0d want 357/18", lba, cnt); end
    n_cmp++; if (busy !== 2'b01) begin n_bad++; $display("FAIL rd18_busy: got %b want 01", busy); end
    tick();
    n_cmp++; if (sd.sd_rd !== 2'b01) begin n_bad++; $display("FAIL rd18_hold: rd %b want 01", sd.sd_rd); end
    do_ack(0);
    n_cmp++; if (ltrack !== 8'd18) begin n_bad++; $display("FAIL rd18_ltrack: got %0d want 18", ltrack); end
    n_cmp++; if (busy !== 2'b00 || drv_act !== 1'b0) begin n_bad++; $display("FAIL rd18_done: busy %b act %b want 00/0", busy, drv_act); end
    wait_req(10, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (ok) begin n_bad++; $display("FAIL rd18_quiet: unexpected request wr %0d lba %0d", is_wr, lba); end
  endtask

  task automatic test_dirty_step();
    bit ok, is_wr; int sub; logic [31:0] lba; logic [5:0] cnt;
    track[0] = 7'd1;
    wait_req(20, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (!ok || is_wr || lba !== 32'd0 || cnt !== 6'd20) begin n_bad++; $display("FAIL step_rd1: ok %0d wr %0d lba %0d cnt %0d want read 0/20", ok, is_wr, lba, cnt); end
    do_ack(0);
    n_cmp++; if (ltrack !== 8'd1) begin n_bad++; $display("FAIL step_ltrack1: got %0d want 1", ltrack); end
    save_track = 2'b01; track[0] = 7'd2;
    tick();
    save_track = 2'b00;
    wait_req(20, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (!ok || !is_wr || lba !== 32'd0 || cnt !== 6'd20) begin n_bad++; $display("FAIL step_wb: ok %0d wr %0d lba %0d cnt %0d want write 0/20", ok, is_wr, lba, cnt); end
    do_ack(0);
    n_cmp++; if (busy !== 2'b01) begin n_bad++; $display("FAIL step_busy_between: got %b want 01", busy); end
    wait_req(20, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (!ok || is_wr || lba !== 32'd21 || cnt !== 6'd20) begin n_bad++; $display("FAIL step_rd2: ok %0d wr %0d lba %0d cnt %0d want read 21/20", ok, is_wr, lba, cnt); end
    do_ack(0);
    n_cmp++; if (ltrack !== 8'd2) begin n_bad++; $display("FAIL step_ltrack2: got %0d want 2", ltrack); end
  endtask

  task automatic test_save_only();
    bit ok, is_wr; int sub; logic [31:0] lba; logic [5:0] cnt;
    save_track = 2'b01;
    tick();
    save_track = 2'b00;
    wait_req(20, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (!ok || !is_wr || sub != 0 || lba !== 32'd21 || cnt !== 6'd20) begin n_bad++; $display("FAIL save_wr: ok %0d wr %0d sub %0d lba %0d cnt %0d want write sub0 21/20", ok, is_wr, sub, lba, cnt); end
    do_ack(0);
    n_cmp++; if (busy !== 2'b00 || ltrack !== 8'd2) begin n_bad++; $display("FAIL save_done: busy %b ltrack %0d want 00/2", busy, ltrack); end
    wait_req(10, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (ok) begin n_bad++; $display("FAIL save_quiet: unexpected request wr %0d lba %0d", is_wr, lba); end
  endtask

  task automatic test_mount_dirty();
    bit ok, is_wr; int sub; logic [31:0] lba; logic [5:0] cnt;
    ce = 1'b0;
    tick();
    save_track = 2'b01;
    tick();
    save_track = 2'b00; mounted = 2'b01;
    tick();
    mounted = 2'b00;
    tick();
    n_cmp++; if (ltrack !== 8'd2 || sd.sd_wr !== 2'b00 || busy !== 2'b00) begin n_bad++; $display("FAIL ce_hold: ltrack %0d wr %b busy %b want 2/00/00", ltrack, sd.sd_wr, busy); end
    ce = 1'b1;
    wait_req(20, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (!ok || is_wr || lba !== 32'd21) begin n_bad++; $display("FAIL mount_reload: ok %0d wr %0d lba %0d want read 21", ok, is_wr, lba); end
    n_cmp++; if (ltrack !== 8'd0) begin n_bad++; $display("FAIL mount_inval: ltrack %0d want 0", ltrack); end
    do_ack(0);
    n_cmp++; if (ltrack !== 8'd2) begin n_bad++; $display("FAIL mount_ltrack: got %0d want 2", ltrack); end
  endtask

  task automatic test_8250();
    bit ok, is_wr; int sub; logic [31:0] lba; logic [5:0] cnt;
    drv_type = 1'b1; drv_hd = 1'b1; track[0] = 7'd39;
    wait_req(20, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (!ok || is_wr || lba !== 32'd3185 || cnt !== 6'd28) begin n_bad++; $display("FAIL d8250_rd: ok %0d wr %0d lba %0d cnt %0d want read 3185/28", ok, is_wr, lba, cnt); end
    do_ack(0);
    n_cmp++; if (ltrack !== 8'd116) begin n_bad++; $display("FAIL d8250_ltrack: got %0d want 116", ltrack); end
  endtask

  task automatic test_invalid();
    bit ok, is_wr; int sub; logic [31:0] lba; logic [5:0] cnt;
    drv_type = 1'b0; drv_hd = 1'b0; track[0] = 7'd36;
    wait_req(10, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (ok) begin n_bad++; $display("FAIL trk36_req: unexpected request lba %0d", lba); end
    n_cmp++; if (ltrack !== 8'd0 || busy !== 2'b00) begin n_bad++; $display("FAIL trk36_state: ltrack %0d busy %b want 0/00", ltrack, busy); end
    track[0] = 7'd0;
    wait_req(10, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (ok || ltrack !== 8'd0 || busy !== 2'b00) begin n_bad++; $display("FAIL trk0: req %0d ltrack %0d busy %b want none/0/00", ok, ltrack, busy); end
    track[0] = 7'd35;
    wait_req(20, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (!ok || is_wr || lba !== 32'd666 || cnt !== 6'd16) begin n_bad++; $display("FAIL trk35_rd: ok %0d wr %0d lba %0d cnt %0d want read 666/16", ok, is_wr, lba, cnt); end
    do_ack(0);
    n_cmp++; if (ltrack !== 8'd35) begin n_bad++; $display("FAIL trk35_ltrack: got %0d want 35", ltrack); end
  endtask

  task automatic test_subdrive1();
    bit ok, is_wr; int sub; logic [31:0] lba; logic [5:0] cnt;
    loaded = 2'b11; drv_mtr = 2'b11; drv_sel = 1'b1; track[1] = 7'd25;
    wait_req(20, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (!ok || is_wr || sub != 1 || lba !== 32'd490 || cnt !== 6'd17) begin n_bad++; $display("FAIL sub1_rd: ok %0d wr %0d sub %0d lba %0d cnt %0d want read sub1 490/17", ok, is_wr, sub, lba, cnt); end
    n_cmp++; if (sd.sd_lba[0] !== 32'd666 || busy !== 2'b10) begin n_bad++; $display("FAIL sub1_other: lba0 %0d busy %b want 666/10", sd.sd_lba[0], busy); end
    do_ack(1);
    n_cmp++; if (drv_act !== 1'b1 || ltrack !== 8'd25) begin n_bad++; $display("FAIL sub1_tag: act %b ltrack %0d want 1/25", drv_act, ltrack); end
  endtask

  task automatic test_motor_off();
    bit ok, is_wr; int sub; logic [31:0] lba; logic [5:0] cnt;
    drv_mtr = 2'b01; track[1] = 7'd26;
    wait_req(10, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (ok || ltrack !== 8'd25) begin n_bad++; $display("FAIL mtr_off_rd: req %0d ltrack %0d want none/25", ok, ltrack); end
    save_track = 2'b10;
    tick();
    save_track = 2'b00;
    wait_req(20, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (!ok || !is_wr || sub != 1 || lba !== 32'd490) begin n_bad++; $display("FAIL mtr_off_wb: ok %0d wr %0d sub %0d lba %0d want write sub1 490", ok, is_wr, sub, lba); end
    do_ack(1);
    wait_req(10, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (ok || busy !== 2'b00) begin n_bad++; $display("FAIL mtr_off_quiet: req %0d busy %b want none/00", ok, busy); end
  endtask

  task automatic test_back_to_back();
    bit ok, is_wr; int sub; logic [31:0] lba; logic [5:0] cnt;
    drv_mtr = 2'b11;
    wait_req(20, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (!ok || is_wr || lba !== 32'd508) begin n_bad++; $display("FAIL b2b_rd26: ok %0d wr %0d lba %0d want read 508", ok, is_wr, lba); end
    track[1] = 7'd27; save_track = 2'b10;
    tick();
    save_track = 2'b00;
    do_ack(1);
    n_cmp++; if (ltrack !== 8'd26) begin n_bad++; $display("FAIL b2b_tag26: got %0d want 26", ltrack); end
    wait_req(20, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (!ok || is_wr || lba !== 32'd526 || cnt !== 6'd17) begin n_bad++; $display("FAIL b2b_rd27: ok %0d wr %0d lba %0d cnt %0d want read 526/17", ok, is_wr, lba, cnt); end
    do_ack(1);
    n_cmp++; if (ltrack !== 8'd27) begin n_bad++; $display("FAIL b2b_tag27: got %0d want 27", ltrack); end
    wait_req(10, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (ok) begin n_bad++; $display("FAIL b2b_quiet: unexpected request wr %0d lba %0d", is_wr, lba); end
  endtask

  task automatic test_reset_mid();
    bit ok, is_wr; int sub; logic [31:0] lba; logic [5:0] cnt;
    track[1] = 7'd28;
    wait_req(20, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (!ok || is_wr || lba !== 32'd544) begin n_bad++; $display("FAIL rstmid_rd: ok %0d wr %0d lba %0d want read 544", ok, is_wr, lba); end
    reset = 1'b1;
    tick();
    n_cmp++; if (sd.sd_rd !== 2'b00 || busy !== 2'b00 || ltrack !== 8'd0) begin n_bad++; $display("FAIL rstmid_drop: rd %b busy %b ltrack %0d want 00/00/0", sd.sd_rd, busy, ltrack); end
    loaded = 2'b00;
    tick();
    reset = 1'b0;
    wait_req(10, ok, is_wr, sub, lba, cnt);
    n_cmp++; if (ok) begin n_bad++; $display("FAIL rstmid_quiet: unexpected request lba %0d", lba); end
  endtask

  initial begin
    test_reset();
    test_read_4040();
    test_dirty_step();
    test_save_only();
    test_mount_dirty();
    test_8250();
    test_invalid();
    test_subdrive1();
    test_motor_off();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
